// File: rtl/debounce_event.sv
// debounce_event: per-channel pad synchronizer, stable-time debouncer,
// registered edge pulses and sticky, maskable event flags with an IRQ.
module debounce_event #(
  parameter int WIDTH         = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int EVT_RISE      = 1,
  parameter int EVT_FALL      = 0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] clr_i,
  input  logic [WIDTH-1:0] irq_en_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  // Pad level that means "not asserted"; the synchronizer idles here.
  localparam logic [WIDTH-1:0] LP_IDLE = {WIDTH{ACTIVE_LOW != 0}};
  localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] LP_RISE_EN = {WIDTH{EVT_RISE != 0}};
  localparam logic [WIDTH-1:0] LP_FALL_EN = {WIDTH{EVT_FALL != 0}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [TIMEOUT_WIDTH-1:0]          r_cnt [WIDTH];
  logic [WIDTH-1:0]                  r_state;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic [WIDTH-1:0]                  r_pend;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_done;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_vis;

  // ---- stage: pad synchronizer (index 0 takes the raw pad) ----
  // Shift raw pads through the synchronizer chain; reset to the idle level.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_sync <= {SYNC_STAGES{LP_IDLE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
    end
  end

  // XOR with the idle level normalizes so that 1 always means asserted.
  assign w_s    = r_sync[SYNC_STAGES-1] ^ LP_IDLE;
  assign w_diff = w_s ^ r_state;

  // ---- stage: stable-time qualification ----
  // A channel is accepted when it has differed for the full timeout window.
  always_comb begin
    w_done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_done[i] = w_diff[i] && (r_cnt[i] == LP_LAST);
    end
  end

  // Per-channel stability counters: restart on agreement or acceptance.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_done[i]) r_cnt[i] <= '0;
        else                         r_cnt[i] <= r_cnt[i] + TIMEOUT_WIDTH'(1);
      end
    end
  end

  // ---- stage: debounced state and edge pulses ----
  // Toggle accepted channels and raise the matching one-cycle pulse.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_state <= r_state ^ w_done;
      r_rise  <= w_done & ~r_state;
      r_fall  <= w_done & r_state;
    end
  end

  // An event sets pending on the edge its pulse rises, and keeps clear off
  // for the whole cycle in which the pulse is visible.
  assign w_set = (w_done & ~r_state & LP_RISE_EN) | (w_done & r_state & LP_FALL_EN);
  assign w_vis = (r_rise & LP_RISE_EN) | (r_fall & LP_FALL_EN);

  // ---- stage: sticky event flags ----
  // Write-1-to-clear flags; any set term wins over a simultaneous clear.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~clr_i) | w_set | w_vis;
    end
  end

  assign data_out  = r_state;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign pending_o = r_pend;
  assign irq_o     = |(r_pend & irq_en_i);

endmodule

// File: doc/debounce_event.md
DEBOUNCE_EVENT -- requirements
Module: debounce_event

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of independent input channels (1..32).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, where 1 means a low pad level is "asserted".
REQ-003 SHALL have parameter TIMEOUT, default 50000, the stable cycles required to accept a change (1 <= TIMEOUT < 2^TIMEOUT_WIDTH).
REQ-004 SHALL have parameter TIMEOUT_WIDTH, default 16, the per-channel counter width.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth (>= 2).
REQ-006 SHALL have parameter EVT_RISE, default 1, where 1 lets an assert edge set pending.
REQ-007 SHALL have parameter EVT_FALL, default 0, where 1 lets a release edge set pending.
REQ-008 SHALL have port wb_clk, input, 1 bit, the single clock.
REQ-009 SHALL have port wb_rst, input, 1 bit, an asynchronous active-high reset.
REQ-010 SHALL have port data_in, input, WIDTH bits, raw asynchronous pad levels.
REQ-011 SHALL have port data_out, output, WIDTH bits, debounced state, active-high (1 = asserted).
REQ-012 SHALL have port rise_o, output, WIDTH bits, one-cycle pulse per channel on accepted 0->1 of data_out.
REQ-013 SHALL have port fall_o, output, WIDTH bits, one-cycle pulse per channel on accepted 1->0 of data_out.
REQ-014 SHALL have port clr_i, input, WIDTH bits, write-1-to-clear strobe for pending_o.
REQ-015 SHALL have port irq_en_i, input, WIDTH bits, per-channel interrupt enable.
REQ-016 SHALL have port pending_o, output, WIDTH bits, sticky event flags.
REQ-017 SHALL have port irq_o, output, 1 bit, equal to OR of (pending_o AND irq_en_i).

Function
REQ-018 SHALL pass each data_in bit through a SYNC_STAGES-deep flip-flop chain, then invert it when ACTIVE_LOW=1, giving the normalized sample s[i].
REQ-019 SHALL, per channel, reset counter cnt[i] to 0 in any cycle where s[i] == data_out[i].
REQ-020 SHALL, per channel, increment cnt[i] by 1 while s[i] != data_out[i] and cnt[i] < TIMEOUT-1.
REQ-021 SHALL, when s[i] != data_out[i] and cnt[i] == TIMEOUT-1, toggle data_out[i] on that clock edge and clear cnt[i] to 0.
REQ-022 SHALL accept a clean input change exactly SYNC_STAGES+TIMEOUT clock edges after it first appears on data_in.
REQ-023 SHALL discard any glitch shorter than TIMEOUT synchronized cycles: counter restarts at 0 and data_out stays unchanged.
REQ-024 SHALL register rise_o[i] and fall_o[i] so they are high in the same cycle data_out[i] first shows its new value, for exactly one cycle.
REQ-025 SHALL set pending_o[i] on the edge where rise_o[i] rises when EVT_RISE=1, and where fall_o[i] rises when EVT_FALL=1.
REQ-026 SHALL clear pending_o[i] one edge after clr_i[i]=1 is sampled.
REQ-027 SHALL let set win over clear when both occur in the same cycle (pending stays 1).
REQ-028 SHALL keep pending_o[i] set on repeated events (sticky, no counting).
REQ-029 SHALL let irq_en_i mask only irq_o: pending_o SHALL record events regardless of enable.
REQ-030 SHALL drive irq_o combinationally from registered pending_o and irq_en_i, with no other logic.
REQ-031 SHALL keep channels fully independent: simultaneous events on several channels all register.
REQ-032 SHALL not let the counter wrap: cnt never exceeds TIMEOUT-1.
REQ-033 SHALL, with TIMEOUT=1, accept a change after one synchronized cycle of difference.

Reset
REQ-034 SHALL on wb_rst=1 asynchronously set data_out, rise_o, fall_o, pending_o and all cnt to 0, and irq_o to 0.
REQ-035 SHALL reset synchronizer stages to the deasserted pad level (1 if ACTIVE_LOW=1, else 0), so no edge is reported after reset with inputs idle.
REQ-036 SHALL, when reset asserts mid-count, abandon the in-progress change; after release the count restarts from 0.

Verification (WIDTH=2, ACTIVE_LOW=1, TIMEOUT=4, SYNC_STAGES=2, EVT_RISE=1, EVT_FALL=0 unless noted)
REQ-037 SHALL cover: data_in[0] 1->0 held -> data_out[0]=1 and rise_o[0] pulses exactly 6 edges later; pending_o[0]=1; irq_o=1 iff irq_en_i[0]=1.
REQ-038 SHALL cover: data_in[1] low for 3 cycles, then high -> data_out[1], rise_o, fall_o and pending_o stay 0.
REQ-039 SHALL cover: clr_i[0]=1 in the same cycle rise_o[0] pulses -> pending_o[0] stays 1; clr_i[0]=1 the next cycle -> pending_o[0]=0 on the following edge.
REQ-040 SHALL cover: EVT_FALL=1, release of an asserted channel -> fall_o pulses one cycle and pending sets; with EVT_FALL=0 pending stays 0.
REQ-041 SHALL cover: wb_rst pulse after 2 cycles of a held press -> all outputs 0 immediately; after release the press is accepted 6 edges after reset deassertion.
REQ-042 SHALL cover: both channels pressed on the same cycle -> both rise_o pulse together; pending_o=2'b11; irq_en_i=2'b10 -> irq_o=1, and clearing ch1 only -> irq_o=0.
